// File: rtl/os_frame_packer_pkg.sv
// Shared frame constants for the oversampled frame packer and its consumer.
package os_frame_packer_pkg;

    // Default frame geometry
    localparam int DEF_SAMPLES = 128;
    localparam int DEF_OSF     = 8;

    // Packer FSM: idle until the first alignment strobe, then collect bits
    typedef enum logic {
        ST_WAIT_SYNC = 1'b0,
        ST_FILL      = 1'b1
    } pack_state_e;

    // Frame width in bits for a given geometry
    function automatic int frame_width(input int samples, input int osf);
        return samples * osf;
    endfunction

    // Width of the fill counter that indexes one frame
    function automatic int count_width(input int samples, input int osf);
        return $clog2(samples * osf);
    endfunction

endpackage

// File: rtl/os_frame_packer.sv
// Serial-to-parallel packer: collects an oversampled 1-bit stream into
// SAMPLES*OSF-bit frames and presents them through a one-deep valid/ready
// holding register. Filling never stalls; a completed frame that finds the
// holding register full and not draining is dropped with an overrun pulse.
module os_frame_packer
    import os_frame_packer_pkg::*;
#(
    parameter  int SAMPLES = DEF_SAMPLES,
    parameter  int OSF     = DEF_OSF,
    localparam int FRAME_W = frame_width(SAMPLES, OSF),
    localparam int CNT_W   = count_width(SAMPLES, OSF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               overrun,
    output logic [CNT_W-1:0]   fill_level
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

    pack_state_e        state, state_nxt;
    logic [FRAME_W-1:0] fill_reg, fill_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [FRAME_W-1:0] hold_reg, hold_nxt;
    logic               hold_valid, hold_valid_nxt;
    logic               overrun_nxt;
    logic               complete;
    logic               xfer;
    logic               load;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WAIT_SYNC;
            fill_reg   <= '0;
            cnt        <= '0;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_reg   <= fill_nxt;
            cnt        <= cnt_nxt;
            hold_reg   <= hold_nxt;
            hold_valid <= hold_valid_nxt;
            overrun    <= overrun_nxt;
        end
    end

    // Next state, indexed bit capture and frame completion detect
    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_reg;
        cnt_nxt   = cnt;
        complete  = 1'b0;
        case (state)
            ST_WAIT_SYNC: begin
                if (sync) begin
                    state_nxt = ST_FILL;
                    if (bit_valid) begin
                        fill_nxt[0] = bit_in;
                        cnt_nxt     = CNT_W'(1);
                    end else begin
                        cnt_nxt = '0;
                    end
                end
            end
            ST_FILL: begin
                // Sync outranks the last-bit completion: the frame restarts.
                if (sync) begin
                    if (bit_valid) begin
                        fill_nxt[0] = bit_in;
                        cnt_nxt     = CNT_W'(1);
                    end else begin
                        cnt_nxt = '0;
                    end
                end else if (bit_valid) begin
                    fill_nxt[cnt] = bit_in;
                    if (cnt == LAST_IDX) begin
                        cnt_nxt  = '0;
                        complete = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = ST_WAIT_SYNC;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Holding register handshake: load on completion when empty or draining
    always_comb begin
        xfer           = hold_valid & frame_ready;
        load           = complete & (~hold_valid | frame_ready);
        hold_nxt       = hold_reg;
        hold_valid_nxt = hold_valid;
        overrun_nxt    = complete & hold_valid & ~frame_ready;
        if (load) begin
            // fill_nxt already carries the final bit of the completing frame.
            hold_nxt       = fill_nxt;
            hold_valid_nxt = 1'b1;
        end else if (xfer) begin
            hold_valid_nxt = 1'b0;
        end
    end

    assign frame_out   = hold_reg;
    assign frame_valid = hold_valid;
    assign fill_level  = cnt;

endmodule
